// File: rtl/fdl_ctrl.sv
// Fine delay line control loop: integrates phase-detector up/dn over fixed windows,
// steps the thermometer code q and hands overflow/underflow to the coarse stage.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   INTEG    | integrating up/dn samples, stepping q at each window end
//   REQ_WAIT | fine range exhausted, coarse request held until coarse_ack
module fdl_ctrl #(
  parameter int          WIN_LEN  = 16,
  parameter int          THRESH   = 4,
  parameter int          LOCK_CNT = 4,
  parameter logic [5:0]  RESET_Q  = 6'b111000
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up,
  input  logic       dn,
  input  logic       coarse_ack,
  output logic [5:0] q,
  output logic       coarse_inc,
  output logic       coarse_dec,
  output logic       locked
);

  localparam int WW = $clog2(WIN_LEN);
  localparam int AW = WW + 2;
  localparam int LW = $clog2(LOCK_CNT + 1);

  localparam logic signed [AW-1:0] THR     = AW'(THRESH);
  localparam logic signed [AW-1:0] NEG_THR = -AW'(THRESH);
  localparam logic [WW-1:0]        WIN_END = WW'(WIN_LEN - 1);
  localparam logic [LW-1:0]        LOCK_MAX = LW'(LOCK_CNT);

  localparam logic [5:0] Q_FULL  = 6'b111111;
  localparam logic [5:0] Q_EMPTY = 6'b000000;

  typedef enum logic {INTEG, REQ_WAIT} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_INC, DIR_DEC} dir_t;

  state_t               state;
  dir_t                 last_dir;
  logic signed [AW-1:0] acc;
  logic [WW-1:0]        win_cnt;
  logic [LW-1:0]        lock_cnt;

  logic signed [AW-1:0] acc_next;
  logic                 win_end;
  logic                 dec_inc;
  logic                 dec_dec;
  logic [LW-1:0]        lock_cnt_next;

  always_comb begin
    acc_next = acc;
    if (up && !dn)
      acc_next = acc + AW'(1);
    else if (dn && !up)
      acc_next = acc - AW'(1);

    win_end = (win_cnt == WIN_END);
    dec_inc = (acc_next >= THR);
    dec_dec = (acc_next <= NEG_THR);

    // A hold or a reversal counts toward lock; a repeated or first step restarts it.
    lock_cnt_next = '0;
    if ((!dec_inc && !dec_dec) ||
        (dec_inc && last_dir == DIR_DEC) ||
        (dec_dec && last_dir == DIR_INC)) begin
      if (lock_cnt == LOCK_MAX)
        lock_cnt_next = lock_cnt;
      else
        lock_cnt_next = lock_cnt + LW'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INTEG;
      last_dir   <= DIR_NONE;
      acc        <= '0;
      win_cnt    <= '0;
      lock_cnt   <= '0;
      q          <= RESET_Q;
      coarse_inc <= 1'b0;
      coarse_dec <= 1'b0;
      locked     <= 1'b0;
    end else begin
      case (state)
        INTEG: begin
          if (en) begin
            if (!win_end) begin
              acc     <= acc_next;
              win_cnt <= win_cnt + WW'(1);
            end else begin
              acc      <= '0;
              win_cnt  <= '0;
              lock_cnt <= lock_cnt_next;
              locked   <= (lock_cnt_next == LOCK_MAX);
              if (dec_inc) begin
                last_dir <= DIR_INC;
                if (q == Q_FULL) begin
                  coarse_inc <= 1'b1;
                  state      <= REQ_WAIT;
                end else begin
                  q <= {1'b1, q[5:1]};
                end
              end else if (dec_dec) begin
                last_dir <= DIR_DEC;
                if (q == Q_EMPTY) begin
                  coarse_dec <= 1'b1;
                  state      <= REQ_WAIT;
                end else begin
                  q <= {q[4:0], 1'b0};
                end
              end
            end
          end
        end

        REQ_WAIT: begin
          if (coarse_ack) begin
            // Re-centre at the opposite end: the coarse step absorbed the full fine range.
            q          <= coarse_inc ? Q_EMPTY : Q_FULL;
            coarse_inc <= 1'b0;
            coarse_dec <= 1'b0;
            acc        <= '0;
            win_cnt    <= '0;
            lock_cnt   <= '0;
            locked     <= 1'b0;
            last_dir   <= DIR_NONE;
            state      <= INTEG;
          end
        end

        default: state <= INTEG;
      endcase
    end
  end

endmodule
